// File: rtl/mul_iter_16bit.sv
// ============================================================================
// Module      : mul_iter_16bit
// Description : Iterative 16x16 signed radix-2 Booth multiplier (one bit per
//               cycle). Define MUL_ZERO_SKIP_EN to finish zero operands at once.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_iter_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Product,
    output logic        Ovfl
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] C_LAST_ITER = 4'd15;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_m;
    logic [16:0] r_hi;
    logic [15:0] r_lo;
    logic        r_q;
    logic [3:0]  r_cnt;
    logic [31:0] r_product;
    logic        r_ovfl;

    logic        w_accept;
    logic        w_zero_skip;
    logic [16:0] w_m_ext;
    logic [16:0] w_hi_sum;
    logic [16:0] w_hi_shift;
    logic [15:0] w_lo_shift;
    logic [31:0] w_prod_next;
    logic        w_ovfl_next;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef MUL_ZERO_SKIP_EN
    assign w_zero_skip = (A == 16'd0) || (B == 16'd0);
`else
    assign w_zero_skip = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_next = w_zero_skip ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == C_LAST_ITER) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // Booth step: Hi is 17 bits wide so that subtracting M = -32768 cannot wrap
    assign w_m_ext = {r_m[15], r_m};

    always_comb begin
        w_hi_sum = r_hi;
        case ({r_lo[0], r_q})
            2'b01:   w_hi_sum = r_hi + w_m_ext;
            2'b10:   w_hi_sum = r_hi - w_m_ext;
            default: w_hi_sum = r_hi;
        endcase
    end

    assign w_hi_shift  = {w_hi_sum[16], w_hi_sum[16:1]};
    assign w_lo_shift  = {w_hi_sum[0], r_lo[15:1]};
    assign w_prod_next = {w_hi_shift[15:0], w_lo_shift};
    assign w_ovfl_next = !((&w_prod_next[31:15]) || (~|w_prod_next[31:15]));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= 16'd0;
            r_hi      <= 17'd0;
            r_lo      <= 16'd0;
            r_q       <= 1'b0;
            r_cnt     <= 4'd0;
            r_product <= 32'd0;
            r_ovfl    <= 1'b0;
        end else if (w_accept) begin
            r_m   <= A;
            r_hi  <= 17'd0;
            r_lo  <= B;
            r_q   <= 1'b0;
            r_cnt <= 4'd0;
            if (w_zero_skip) begin
                r_product <= 32'd0;
                r_ovfl    <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_hi  <= w_hi_shift;
            r_lo  <= w_lo_shift;
            r_q   <= r_lo[0];
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == C_LAST_ITER) begin
                r_product <= w_prod_next;
                r_ovfl    <= w_ovfl_next;
            end
        end
    end

    assign Product = r_product;
    assign Ovfl    = r_ovfl;

endmodule

`default_nettype wire
